// File: rtl/sp_usb_fifo_dev_if.sv
// Strobe/flag handshake plus local byte-stream port of the FT245-style device model.
// The shared tristate data bus stays a plain inout on the device module.
interface sp_usb_fifo_dev_if;
  logic       rxf_n;
  logic       txe_n;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] din;
  logic       write;
  logic       full;
  logic [7:0] dout;
  logic       read;
  logic       avail;

  modport slave  (input  rd_n, wr_n, din, write, read,
                  output rxf_n, txe_n, full, dout, avail);
  modport master (output rd_n, wr_n, din, write, read,
                  input  rxf_n, txe_n, full, dout, avail);
endinterface

// File: rtl/sp_usb_fifo_dev.sv
// Device side of an FT245-style synchronous USB FIFO: answers rd_n/wr_n strobes
// on the shared bus and bridges them to a local byte stream through TXQ/RXQ.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | flags track FIFO levels, waiting for an armed strobe edge
// S_READ    | bus driven with TXQ head until rd_n rises, then pop
// S_WRITE   | byte already pushed into RXQ, waiting for wr_n to rise
// S_RECOVER | flags held high for RECOVER_CYCLES clocks
module sp_usb_fifo_dev #(
  parameter int DEPTH_LOG2     = 4,
  parameter int RECOVER_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [7:0]       usb_data,
  sp_usb_fifo_dev_if.slave u_if
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [DEPTH_LOG2:0] C_FULL      = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] C_ONE_SHORT = {1'b0, {DEPTH_LOG2{1'b1}}};
  localparam logic [CW-1:0]       C_REC_LOAD  = CW'(RECOVER_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RECOVER} state_t;

  state_t              r_state;
  logic                r_rd_s1, r_rd_s2, r_wr_s1, r_wr_s2;
  logic [7:0]          r_data_s1;
  logic                r_rxf_n, r_txe_n, r_rd_armed;
  logic [CW-1:0]       r_rec_cnt;

  logic [7:0]            r_txq_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_txq_wp, r_txq_rp;
  logic [DEPTH_LOG2:0]   r_txq_cnt;
  logic [7:0]            r_rxq_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_rxq_wp, r_rxq_rp;
  logic [DEPTH_LOG2:0]   r_rxq_cnt;

  logic w_rd_fall, w_rd_rise, w_wr_fall, w_wr_rise;
  logic w_txq_empty, w_txq_full, w_rxq_empty, w_rxq_full;
  logic w_rd_take, w_rxq_push, w_txq_pop, w_txq_push, w_rxq_pop;
  logic w_bus_oe;

  assign w_rd_fall = !r_rd_s1 &&  r_rd_s2;
  assign w_rd_rise =  r_rd_s1 && !r_rd_s2;
  assign w_wr_fall = !r_wr_s1 &&  r_wr_s2;
  assign w_wr_rise =  r_wr_s1 && !r_wr_s2;

  assign w_txq_empty = (r_txq_cnt == '0);
  assign w_txq_full  = (r_txq_cnt == C_FULL);
  assign w_rxq_empty = (r_rxq_cnt == '0);
  assign w_rxq_full  = (r_rxq_cnt == C_FULL);

  // Read beats write when both strobes fall together.
  assign w_rd_take  = (r_state == S_IDLE) && w_rd_fall && r_rd_armed;
  assign w_rxq_push = (r_state == S_IDLE) && !w_rd_take && w_wr_fall &&
                      !r_txe_n && !w_rxq_full;
  assign w_txq_pop  = (r_state == S_READ) && w_rd_rise && !w_txq_empty;
  assign w_txq_push = u_if.write && !w_txq_full;
  assign w_rxq_pop  = u_if.read && !w_rxq_empty;

  assign w_bus_oe = !u_if.rd_n && r_rd_armed;
  assign usb_data = w_bus_oe ? r_txq_mem[r_txq_rp] : 8'hzz;

  assign u_if.rxf_n = r_rxf_n;
  assign u_if.txe_n = r_txe_n;
  assign u_if.full  = w_txq_full || (u_if.write && (r_txq_cnt == C_ONE_SHORT));
  assign u_if.avail = !w_rxq_empty;
  assign u_if.dout  = w_rxq_empty ? 8'h00 : r_rxq_mem[r_rxq_rp];

  // Stages reset to 0 so a strobe held low through reset is not seen as a new fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_s1   <= 1'b0;
      r_rd_s2   <= 1'b0;
      r_wr_s1   <= 1'b0;
      r_wr_s2   <= 1'b0;
      r_data_s1 <= 8'h00;
    end else begin
      r_rd_s1   <= u_if.rd_n;
      r_rd_s2   <= r_rd_s1;
      r_wr_s1   <= u_if.wr_n;
      r_wr_s2   <= r_wr_s1;
      r_data_s1 <= usb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_txq_push) r_txq_mem[r_txq_wp] <= u_if.din;
    if (w_rxq_push) r_rxq_mem[r_rxq_wp] <= r_data_s1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txq_wp  <= '0;
      r_txq_rp  <= '0;
      r_txq_cnt <= '0;
      r_rxq_wp  <= '0;
      r_rxq_rp  <= '0;
      r_rxq_cnt <= '0;
    end else begin
      if (w_txq_push) r_txq_wp <= r_txq_wp + DEPTH_LOG2'(1);
      if (w_txq_pop)  r_txq_rp <= r_txq_rp + DEPTH_LOG2'(1);
      r_txq_cnt <= r_txq_cnt + (DEPTH_LOG2+1)'(w_txq_push) - (DEPTH_LOG2+1)'(w_txq_pop);
      if (w_rxq_push) r_rxq_wp <= r_rxq_wp + DEPTH_LOG2'(1);
      if (w_rxq_pop)  r_rxq_rp <= r_rxq_rp + DEPTH_LOG2'(1);
      r_rxq_cnt <= r_rxq_cnt + (DEPTH_LOG2+1)'(w_rxq_push) - (DEPTH_LOG2+1)'(w_rxq_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rxf_n    <= 1'b1;
      r_txe_n    <= 1'b1;
      r_rd_armed <= 1'b0;
      r_rec_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rxf_n <= w_txq_empty;
          r_txe_n <= w_rxq_full;
          // Arm together with rxf_n falling so the bus answers on the very first rd_n low.
          if (!w_txq_empty) r_rd_armed <= 1'b1;
          if (w_rd_take) begin
            r_state <= S_READ;
            r_rxf_n <= 1'b1;
            r_txe_n <= 1'b1;
          end else if (w_rxq_push) begin
            r_state <= S_WRITE;
            r_rxf_n <= 1'b1;
            r_txe_n <= 1'b1;
          end
        end
        S_READ: begin
          if (w_rd_rise) begin
            r_rd_armed <= 1'b0;
            r_rec_cnt  <= C_REC_LOAD;
            r_state    <= S_RECOVER;
          end
        end
        S_WRITE: begin
          if (w_wr_rise) begin
            r_rec_cnt <= C_REC_LOAD;
            r_state   <= S_RECOVER;
          end
        end
        S_RECOVER: begin
          if (r_rec_cnt == '0) r_state <= S_IDLE;
          else                 r_rec_cnt <= r_rec_cnt - CW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_usb_fifo_dev.sv
// Directed + randomized bench for sp_usb_fifo_dev against a queue-based model of
// both FIFOs and the handshake timing rules (2 sync + RECOVER + 1 clocks).
module tb_sp_usb_fifo_dev;
  localparam int REC   = 3;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  wire  [7:0] usb_data;
  logic       tb_oe;
  logic [7:0] tb_data;
  assign usb_data = tb_oe ? tb_data : 8'hzz;

  sp_usb_fifo_dev_if bus_if ();

  sp_usb_fifo_dev #(.DEPTH_LOG2(4), .RECOVER_CYCLES(REC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .usb_data (usb_data),
    .u_if     (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] txq_m [$];
  logic [7:0] rxq_m [$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic local_write(input logic [7:0] b);
    bus_if.din   = b;
    bus_if.write = 1'b1;
    #1 chk("lw_full", 16'(bus_if.full), 16'(txq_m.size() >= DEPTH - 1));
    step();
    if (txq_m.size() < DEPTH) txq_m.push_back(b);
    bus_if.write = 1'b0;
  endtask

  task automatic local_read();
    chk("lr_avail", 16'(bus_if.avail), 16'(rxq_m.size() > 0));
    if (rxq_m.size() > 0) chk("lr_dout", 16'(bus_if.dout), 16'(rxq_m[0]));
    bus_if.read = 1'b1;
    step();
    bus_if.read = 1'b0;
    if (rxq_m.size() > 0) void'(rxq_m.pop_front());
  endtask

  // Flags must stay high for 2 sync + REC clocks after the strobe rises, then follow the queues.
  task automatic recover_check(input bit pop_tx, input bit coinc_w);
    bit acc;
    for (int i = 1; i <= 2 + REC; i++) begin
      acc = 1'b0;
      if (i == 2 && coinc_w) begin
        bus_if.din   = 8'($urandom);
        bus_if.write = 1'b1;
        acc = (txq_m.size() < DEPTH);
        #1 chk("coinc_full", 16'(bus_if.full), 16'(txq_m.size() >= DEPTH - 1));
      end
      step();
      if (i == 2) begin
        if (pop_tx && txq_m.size() > 0) void'(txq_m.pop_front());
        if (acc) txq_m.push_back(bus_if.din);
        bus_if.write = 1'b0;
      end
      chk("rec_flags", 16'({bus_if.rxf_n, bus_if.txe_n}), 16'h3);
    end
    step();
    chk("rec_rxf_n", 16'(bus_if.rxf_n), 16'(txq_m.size() == 0));
    chk("rec_txe_n", 16'(bus_if.txe_n), 16'(rxq_m.size() == DEPTH));
  endtask

  task automatic bus_read(input int hold, input bit with_wr, input bit coinc_w);
    int t = 0;
    logic [7:0] exp;
    while (bus_if.rxf_n !== 1'b0 && t < 100) begin step(); t++; end
    chk("rd_wait_rxf", 16'(bus_if.rxf_n), 16'h0);
    exp = (txq_m.size() > 0) ? txq_m[0] : 8'h00;
    bus_if.rd_n = 1'b0;
    if (with_wr) bus_if.wr_n = 1'b0;
    #1 chk("rd_oe", 16'(dut.w_bus_oe), 16'h1);
    chk("rd_data0", 16'(usb_data), 16'(exp));
    for (int i = 1; i <= hold; i++) begin
      step();
      chk("rd_data", 16'(usb_data), 16'(exp));
      if (i >= 2) chk("rd_flags", 16'({bus_if.rxf_n, bus_if.txe_n}), 16'h3);
    end
    bus_if.rd_n = 1'b1;
    bus_if.wr_n = 1'b1;
    #1 chk("rd_release_oe", 16'(dut.w_bus_oe), 16'h0);
    recover_check(1'b1, coinc_w);
  endtask

  task automatic bus_write(input logic [7:0] b, input int hold, input bit coinc_r);
    int t = 0;
    while (bus_if.txe_n !== 1'b0 && t < 100) begin step(); t++; end
    chk("wr_wait_txe", 16'(bus_if.txe_n), 16'h0);
    tb_data     = b;
    tb_oe       = 1'b1;
    bus_if.wr_n = 1'b0;
    for (int i = 1; i <= hold; i++) begin
      if (i == 2 && coinc_r && rxq_m.size() > 0) begin
        chk("coinc_dout", 16'(bus_if.dout), 16'(rxq_m[0]));
        bus_if.read = 1'b1;
      end
      step();
      if (i == 2) begin
        if (bus_if.read) void'(rxq_m.pop_front());
        bus_if.read = 1'b0;
        rxq_m.push_back(b);
      end
      if (i >= 2) chk("wr_flags", 16'({bus_if.rxf_n, bus_if.txe_n}), 16'h3);
    end
    bus_if.wr_n = 1'b1;
    tb_oe       = 1'b0;
    recover_check(1'b0, 1'b0);
    chk("wr_avail", 16'(bus_if.avail), 16'h1);
    chk("wr_dout", 16'(bus_if.dout), 16'(rxq_m[0]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    rst_n = 1'b0; tb_oe = 1'b0; tb_data = 8'h00;
    bus_if.rd_n = 1'b1; bus_if.wr_n = 1'b1;
    bus_if.din = 8'h00; bus_if.write = 1'b0; bus_if.read = 1'b0;
    repeat (3) step();
    chk("rst_rxf_n", 16'(bus_if.rxf_n), 16'h1);
    chk("rst_txe_n", 16'(bus_if.txe_n), 16'h1);
    chk("rst_full",  16'(bus_if.full),  16'h0);
    chk("rst_avail", 16'(bus_if.avail), 16'h0);
    chk("rst_dout",  16'(bus_if.dout),  16'h0);
    chk("rst_oe",    16'(dut.w_bus_oe), 16'h0);
    rst_n = 1'b1;
    step();
    chk("idle_txe_n", 16'(bus_if.txe_n), 16'h0);
    chk("idle_rxf_n", 16'(bus_if.rxf_n), 16'h1);

    // Read strobe with nothing to send is ignored.
    bus_if.rd_n = 1'b0;
    #1 chk("unarmed_oe", 16'(dut.w_bus_oe), 16'h0);
    repeat (4) begin step(); chk("unarmed_oe_hold", 16'(dut.w_bus_oe), 16'h0); end
    bus_if.rd_n = 1'b1;
    repeat (3) step();
    chk("unarmed_txe_n", 16'(bus_if.txe_n), 16'h0);

    // First local write: rxf_n falls two clocks later.
    local_write(8'hA5);
    chk("rxf_lat1", 16'(bus_if.rxf_n), 16'h1);
    step();
    chk("rxf_lat2", 16'(bus_if.rxf_n), 16'h0);
    bus_read(3, 1'b0, 1'b0);

    bus_write(8'h3C, 3, 1'b0);
    local_read();
    local_read();
    chk("avail_after_pop", 16'(bus_if.avail), 16'h0);

    // Fill RXQ, 17th strobe ignored, drain in order.
    for (int i = 0; i < DEPTH; i++) bus_write(8'(i), $urandom_range(2, 4), 1'b0);
    chk("rxq_full_txe", 16'(bus_if.txe_n), 16'h1);
    tb_data = 8'hEE; tb_oe = 1'b1; bus_if.wr_n = 1'b0;
    repeat (3) begin step(); chk("wr17_txe", 16'(bus_if.txe_n), 16'h1); end
    bus_if.wr_n = 1'b1; tb_oe = 1'b0;
    repeat (6) begin step(); chk("wr17_idle", 16'(bus_if.txe_n), 16'h1); end
    for (int i = 0; i < DEPTH; i++) local_read();
    chk("drain_avail", 16'(bus_if.avail), 16'h0);
    step();
    chk("drain_txe", 16'(bus_if.txe_n), 16'h0);

    // Both strobes fall together: read wins, write dropped.
    local_write(8'($urandom));
    bus_read(3, 1'b1, 1'b0);
    chk("both_no_push", 16'(bus_if.avail), 16'h0);

    // TXQ full boundary, then randomized traffic.
    for (int i = 0; i <= DEPTH; i++) local_write(8'($urandom));
    chk("txq_full", 16'(bus_if.full), 16'h1);
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0: local_write(8'($urandom));
        1: if (txq_m.size() > 0) bus_read($urandom_range(2, 5), 1'b0, 1'($urandom_range(0, 1)));
        2: if (rxq_m.size() < DEPTH) bus_write(8'($urandom), $urandom_range(2, 5), 1'($urandom_range(0, 1)));
        default: local_read();
      endcase
    end
    while (txq_m.size() > 0) bus_read(2, 1'b0, 1'b0);
    while (rxq_m.size() > 0) local_read();
    chk("end_avail", 16'(bus_if.avail), 16'h0);

    // Reset while rd_n is low.
    local_write(8'h5A);
    bus_read(2, 1'b0, 1'b0);
    local_write(8'h77);
    step();
    bus_if.rd_n = 1'b0;
    #1 chk("mid_rd_oe", 16'(dut.w_bus_oe), 16'h1);
    step();
    rst_n = 1'b0;
    #1 chk("mid_rst_oe", 16'(dut.w_bus_oe), 16'h0);
    chk("mid_rst_rxf", 16'(bus_if.rxf_n), 16'h1);
    chk("mid_rst_avail", 16'(bus_if.avail), 16'h0);
    txq_m.delete();
    rxq_m.delete();
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("post_rst_txe", 16'(bus_if.txe_n), 16'h0);
    chk("post_rst_rxf", 16'(bus_if.rxf_n), 16'h1);
    chk("post_rst_oe", 16'(dut.w_bus_oe), 16'h0);
    b = 8'($urandom);
    local_write(b);
    step();
    chk("held_rd_oe", 16'(dut.w_bus_oe), 16'h1);
    chk("held_rd_data", 16'(usb_data), 16'(b));
    repeat (6) begin step(); chk("held_no_pop", 16'(bus_if.rxf_n), 16'h0); end
    bus_if.rd_n = 1'b1;
    repeat (2) step();
    bus_read(3, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
